// File: rtl/request_dispatcher_pkg.sv
// Shared widths, meta-word field offsets and dispatcher state encoding for the
// request dispatcher slice.
package lb_pkg;

  localparam int HTTP_DATA_WIDTH_DEF   = 32'd512;
  localparam int HTTP_META_WIDTH_DEF   = 32'd98;
  localparam int OPERATOR_ID_WIDTH_DEF = 32'd16;
  localparam int N_REGIONS_DEF         = 32'd4;
  localparam int CNT_WIDTH_DEF         = 32'd32;

  // Meta word layout: {meta_meta[47:0], method[31:0], has_hdr, has_bdy, oid}
  localparam int OID_LSB       = 32'd0;
  localparam int HAS_BDY_BIT   = OPERATOR_ID_WIDTH_DEF;
  localparam int HAS_HDR_BIT   = OPERATOR_ID_WIDTH_DEF + 32'd1;
  localparam int METHOD_LSB    = OPERATOR_ID_WIDTH_DEF + 32'd2;
  localparam int META_META_LSB = METHOD_LSB + 32'd32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    META = 2'd1,
    HDR  = 2'd2,
    BDY  = 2'd3
  } dispatch_state_t;

endpackage

// File: rtl/request_dispatcher_if.sv
// Request streams around the dispatcher: meta/header/body inputs and the
// per-region valid/ready outputs with broadcast payload.
interface request_dispatcher_if #(
  parameter int DATA_W = lb_pkg::HTTP_DATA_WIDTH_DEF,
  parameter int META_W = lb_pkg::HTTP_META_WIDTH_DEF,
  parameter int N      = lb_pkg::N_REGIONS_DEF
) ();

  localparam int KEEP_W = DATA_W / 32'd8;

  logic              meta_in_tvalid;
  logic              meta_in_tready;
  logic [META_W-1:0] meta_in_tdata;

  logic              hdr_in_tvalid;
  logic              hdr_in_tready;
  logic [DATA_W-1:0] hdr_in_tdata;
  logic [KEEP_W-1:0] hdr_in_tkeep;
  logic              hdr_in_tlast;

  logic              bdy_in_tvalid;
  logic              bdy_in_tready;
  logic [DATA_W-1:0] bdy_in_tdata;
  logic [KEEP_W-1:0] bdy_in_tkeep;
  logic              bdy_in_tlast;

  logic [N-1:0]      meta_out_tvalid;
  logic [N-1:0]      meta_out_tready;
  logic [META_W-1:0] meta_out_tdata;

  logic [N-1:0]      hdr_out_tvalid;
  logic [N-1:0]      hdr_out_tready;
  logic [DATA_W-1:0] hdr_out_tdata;
  logic [KEEP_W-1:0] hdr_out_tkeep;
  logic              hdr_out_tlast;

  logic [N-1:0]      bdy_out_tvalid;
  logic [N-1:0]      bdy_out_tready;
  logic [DATA_W-1:0] bdy_out_tdata;
  logic [KEEP_W-1:0] bdy_out_tkeep;
  logic              bdy_out_tlast;

  modport slave (
    input  meta_in_tvalid, meta_in_tdata,
    output meta_in_tready,
    input  hdr_in_tvalid, hdr_in_tdata, hdr_in_tkeep, hdr_in_tlast,
    output hdr_in_tready,
    input  bdy_in_tvalid, bdy_in_tdata, bdy_in_tkeep, bdy_in_tlast,
    output bdy_in_tready,
    output meta_out_tvalid, meta_out_tdata,
    input  meta_out_tready,
    output hdr_out_tvalid, hdr_out_tdata, hdr_out_tkeep, hdr_out_tlast,
    input  hdr_out_tready,
    output bdy_out_tvalid, bdy_out_tdata, bdy_out_tkeep, bdy_out_tlast,
    input  bdy_out_tready
  );

  modport master (
    output meta_in_tvalid, meta_in_tdata,
    input  meta_in_tready,
    output hdr_in_tvalid, hdr_in_tdata, hdr_in_tkeep, hdr_in_tlast,
    input  hdr_in_tready,
    output bdy_in_tvalid, bdy_in_tdata, bdy_in_tkeep, bdy_in_tlast,
    input  bdy_in_tready,
    input  meta_out_tvalid, meta_out_tdata,
    output meta_out_tready,
    input  hdr_out_tvalid, hdr_out_tdata, hdr_out_tkeep, hdr_out_tlast,
    output hdr_out_tready,
    input  bdy_out_tvalid, bdy_out_tdata, bdy_out_tkeep, bdy_out_tlast,
    output bdy_out_tready
  );

endinterface

// File: rtl/request_dispatcher_demux.sv
// Generic 1-to-N valid/ready pass-through: while enabled, the selected output
// sees the input valid and drives the input ready; payload is broadcast.
module stream_demux
  import lb_pkg::*;
#(
  parameter  int DATA_W = HTTP_DATA_WIDTH_DEF,
  parameter  int KEEP_W = DATA_W / 32'd8,
  parameter  int N      = N_REGIONS_DEF,
  localparam int SEL_W  = $clog2(N)
) (
  input  logic              en,
  input  logic [SEL_W-1:0]  sel,
  input  logic              in_tvalid,
  output logic              in_tready,
  input  logic [DATA_W-1:0] in_tdata,
  input  logic [KEEP_W-1:0] in_tkeep,
  input  logic              in_tlast,
  output logic [N-1:0]      out_tvalid,
  input  logic [N-1:0]      out_tready,
  output logic [DATA_W-1:0] out_tdata,
  output logic [KEEP_W-1:0] out_tkeep,
  output logic              out_tlast,
  output logic              last_beat
);

  // Route valid to the selected region and its ready back upstream.
  always_comb begin
    out_tvalid = {N{1'b0}};
    in_tready  = 1'b0;
    if (en) begin
      out_tvalid[sel] = in_tvalid;
      in_tready       = out_tready[sel];
    end else begin
      out_tvalid = {N{1'b0}};
      in_tready  = 1'b0;
    end
  end

  assign out_tdata = in_tdata;
  assign out_tkeep = in_tkeep;
  assign out_tlast = in_tlast;
  assign last_beat = en & in_tvalid & in_tready & in_tlast;

endmodule

// File: rtl/request_dispatcher.sv
// Steers each request (meta, then header, then body) atomically to one region.
// Optional per-region dispatch counters are built when DISPATCH_CNT_EN is defined.
module request_dispatcher
  import lb_pkg::*;
#(
  parameter  int HTTP_DATA_WIDTH   = HTTP_DATA_WIDTH_DEF,
  parameter  int HTTP_META_WIDTH   = HTTP_META_WIDTH_DEF,
  parameter  int OPERATOR_ID_WIDTH = OPERATOR_ID_WIDTH_DEF,
  parameter  int N_REGIONS         = N_REGIONS_DEF,
  parameter  int CNT_WIDTH         = CNT_WIDTH_DEF,
  localparam int SEL_W             = $clog2(N_REGIONS)
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [SEL_W-1:0]              lb_ctrl,
  request_dispatcher_if.slave           bus,
  output logic                          busy
`ifdef DISPATCH_CNT_EN
  ,
  output logic [N_REGIONS*CNT_WIDTH-1:0] dispatch_cnt
`endif
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_META = META;
  localparam logic [1:0] ST_HDR  = HDR;
  localparam logic [1:0] ST_BDY  = BDY;

  localparam int KEEP_W = HTTP_DATA_WIDTH / 32'd8;
  localparam logic [N_REGIONS-1:0] ONEHOT_BASE = {{(N_REGIONS-1){1'b0}}, 1'b1};

  logic [1:0]                 state_r;
  logic [1:0]                 state_nxt_s;
  logic [SEL_W-1:0]           sel_r;
  logic [HTTP_META_WIDTH-1:0] meta_r;
  logic                       busy_r;
  logic                       has_hdr_s;
  logic                       has_bdy_s;
  logic                       meta_out_hs_s;
  logic                       hdr_en_s;
  logic                       bdy_en_s;
  logic                       hdr_last_s;
  logic                       bdy_last_s;
  logic [N_REGIONS-1:0]       sel_onehot_s;

  assign has_hdr_s     = meta_r[OPERATOR_ID_WIDTH + 1];
  assign has_bdy_s     = meta_r[OPERATOR_ID_WIDTH];
  assign sel_onehot_s  = ONEHOT_BASE << sel_r;
  assign meta_out_hs_s = (state_r == ST_META) && bus.meta_out_tready[sel_r];
  assign hdr_en_s      = (state_r == ST_HDR);
  assign bdy_en_s      = (state_r == ST_BDY);

  // Request sequencing: meta, then optional header, then optional body.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.meta_in_tvalid) state_nxt_s = ST_META;
        else                    state_nxt_s = ST_IDLE;
      end
      ST_META: begin
        if (meta_out_hs_s) begin
          if (has_hdr_s)      state_nxt_s = ST_HDR;
          else if (has_bdy_s) state_nxt_s = ST_BDY;
          else                state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_META;
        end
      end
      ST_HDR: begin
        if (hdr_last_s) begin
          if (has_bdy_s) state_nxt_s = ST_BDY;
          else           state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HDR;
        end
      end
      ST_BDY: begin
        if (bdy_last_s) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_BDY;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, latched decision and meta word; lb_ctrl is only sampled on meta accept.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r <= ST_IDLE;
      sel_r   <= {SEL_W{1'b0}};
      meta_r  <= {HTTP_META_WIDTH{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      if ((state_r == ST_IDLE) && bus.meta_in_tvalid) begin
        sel_r  <= lb_ctrl;
        meta_r <= bus.meta_in_tdata;
      end else begin
        sel_r  <= sel_r;
        meta_r <= meta_r;
      end
    end
  end

  assign bus.meta_in_tready  = (state_r == ST_IDLE);
  assign bus.meta_out_tvalid = (state_r == ST_META) ? sel_onehot_s : {N_REGIONS{1'b0}};
  assign bus.meta_out_tdata  = meta_r;
  assign busy                = busy_r;

  stream_demux #(
    .DATA_W (HTTP_DATA_WIDTH),
    .KEEP_W (KEEP_W),
    .N      (N_REGIONS)
  ) u_hdr_demux (
    .en         (hdr_en_s),
    .sel        (sel_r),
    .in_tvalid  (bus.hdr_in_tvalid),
    .in_tready  (bus.hdr_in_tready),
    .in_tdata   (bus.hdr_in_tdata),
    .in_tkeep   (bus.hdr_in_tkeep),
    .in_tlast   (bus.hdr_in_tlast),
    .out_tvalid (bus.hdr_out_tvalid),
    .out_tready (bus.hdr_out_tready),
    .out_tdata  (bus.hdr_out_tdata),
    .out_tkeep  (bus.hdr_out_tkeep),
    .out_tlast  (bus.hdr_out_tlast),
    .last_beat  (hdr_last_s)
  );

  stream_demux #(
    .DATA_W (HTTP_DATA_WIDTH),
    .KEEP_W (KEEP_W),
    .N      (N_REGIONS)
  ) u_bdy_demux (
    .en         (bdy_en_s),
    .sel        (sel_r),
    .in_tvalid  (bus.bdy_in_tvalid),
    .in_tready  (bus.bdy_in_tready),
    .in_tdata   (bus.bdy_in_tdata),
    .in_tkeep   (bus.bdy_in_tkeep),
    .in_tlast   (bus.bdy_in_tlast),
    .out_tvalid (bus.bdy_out_tvalid),
    .out_tready (bus.bdy_out_tready),
    .out_tdata  (bus.bdy_out_tdata),
    .out_tkeep  (bus.bdy_out_tkeep),
    .out_tlast  (bus.bdy_out_tlast),
    .last_beat  (bdy_last_s)
  );

`ifdef DISPATCH_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [N_REGIONS*CNT_WIDTH-1:0] cnt_r;

  // Per-region request counters, bumped on each meta handshake; wrap naturally.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt_r <= {(N_REGIONS*CNT_WIDTH){1'b0}};
    end else begin
      for (int r = 0; r < N_REGIONS; r++) begin
        if (meta_out_hs_s && (sel_r == SEL_W'(r))) begin
          cnt_r[r*CNT_WIDTH +: CNT_WIDTH] <= cnt_r[r*CNT_WIDTH +: CNT_WIDTH] + CNT_ONE;
        end else begin
          cnt_r[r*CNT_WIDTH +: CNT_WIDTH] <= cnt_r[r*CNT_WIDTH +: CNT_WIDTH];
        end
      end
    end
  end

  assign dispatch_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_request_dispatcher.sv
// Directed bench for request_dispatcher: inputs change 1 ns after the rising
// edge, outputs are sampled on the falling edge.
module tb_request_dispatcher;
  import lb_pkg::*;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [1:0]   lb_ctrl;
  logic         busy;
`ifdef DISPATCH_CNT_EN
  logic [127:0] dispatch_cnt;
`endif

  always #5 aclk = ~aclk;

  request_dispatcher_if #(.DATA_W(512), .META_W(98), .N(4)) bus ();

  request_dispatcher dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .lb_ctrl (lb_ctrl),
    .bus     (bus),
    .busy    (busy)
`ifdef DISPATCH_CNT_EN
    ,
    .dispatch_cnt (dispatch_cnt)
`endif
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input int r);
    logic [3:0] b;
    b = 4'b0001;
    return b << r;
  endfunction

  task automatic check_cnt(input string tag, input logic [127:0] exp);
`ifdef DISPATCH_CNT_EN
    check_val(tag, dispatch_cnt, exp);
`else
    if (exp === 128'hx) $display("no counters");
`endif
  endtask

  task automatic idle_inputs();
    bus.meta_in_tvalid  = 1'b0; bus.meta_in_tdata = '0;
    bus.hdr_in_tvalid   = 1'b0; bus.hdr_in_tdata  = '0; bus.hdr_in_tkeep = '0; bus.hdr_in_tlast = 1'b0;
    bus.bdy_in_tvalid   = 1'b0; bus.bdy_in_tdata  = '0; bus.bdy_in_tkeep = '0; bus.bdy_in_tlast = 1'b0;
    bus.meta_out_tready = 4'h0; bus.hdr_out_tready = 4'h0; bus.bdy_out_tready = 4'h0;
  endtask

  // Offer a meta word with lb_ctrl=r; the target region withholds ready for 'hold' cycles.
  task automatic send_meta(input int r, input logic [97:0] m, input int hold);
    lb_ctrl = 2'(r);
    bus.meta_in_tvalid = 1'b1;
    bus.meta_in_tdata  = m;
    @(negedge aclk);
    check_val("meta_in_rdy", bus.meta_in_tready, 1'b1);
    check_val("idle_busy", busy, 1'b0);
    check_val("idle_bdy_rdy", bus.bdy_in_tready, 1'b0);
    @(posedge aclk); #1;
    bus.meta_in_tvalid = 1'b0;
    bus.meta_in_tdata  = '0;
    for (int i = 0; i < hold; i++) begin
      bus.meta_out_tready = ~onehot(r);
      @(negedge aclk);
      check_val("meta_hold_vld", bus.meta_out_tvalid, onehot(r));
      check_val("meta_hold_dat", bus.meta_out_tdata, m);
      check_val("meta_hold_bdy_rdy", bus.bdy_in_tready, 1'b0);
      @(posedge aclk); #1;
    end
    bus.meta_out_tready = onehot(r);
    @(negedge aclk);
    check_val("meta_vld", bus.meta_out_tvalid, onehot(r));
    check_val("meta_dat", bus.meta_out_tdata, m);
    check_val("meta_in_rdy_busy", bus.meta_in_tready, 1'b0);
    check_val("meta_busy", busy, 1'b1);
    check_val("meta_hdr_rdy", bus.hdr_in_tready, 1'b0);
    check_val("meta_bdy_rdy", bus.bdy_in_tready, 1'b0);
    @(posedge aclk); #1;
    bus.meta_out_tready = 4'h0;
  endtask

  // One header (bdy=0) or body (bdy=1) beat expected on region r.
  task automatic send_beat(input bit bdy, input int r, input logic [511:0] d,
                           input logic [63:0] k, input logic l);
    if (bdy) begin
      bus.bdy_in_tvalid = 1'b1; bus.bdy_in_tdata = d; bus.bdy_in_tkeep = k; bus.bdy_in_tlast = l;
      bus.bdy_out_tready = onehot(r);
    end else begin
      bus.hdr_in_tvalid = 1'b1; bus.hdr_in_tdata = d; bus.hdr_in_tkeep = k; bus.hdr_in_tlast = l;
      bus.hdr_out_tready = onehot(r);
    end
    @(negedge aclk);
    if (bdy) begin
      check_val("bdy_vld", bus.bdy_out_tvalid, onehot(r));
      check_val("bdy_rdy", bus.bdy_in_tready, 1'b1);
      check_val("bdy_dat", bus.bdy_out_tdata, d);
      check_val("bdy_keep", bus.bdy_out_tkeep, k);
      check_val("bdy_last", bus.bdy_out_tlast, l);
      check_val("bdy_hdr_idle", bus.hdr_out_tvalid, 4'h0);
    end else begin
      check_val("hdr_vld", bus.hdr_out_tvalid, onehot(r));
      check_val("hdr_rdy", bus.hdr_in_tready, 1'b1);
      check_val("hdr_dat", bus.hdr_out_tdata, d);
      check_val("hdr_keep", bus.hdr_out_tkeep, k);
      check_val("hdr_last", bus.hdr_out_tlast, l);
      check_val("hdr_bdy_idle", bus.bdy_out_tvalid, 4'h0);
    end
    check_val("beat_meta_idle", bus.meta_out_tvalid, 4'h0);
    check_val("beat_busy", busy, 1'b1);
    @(posedge aclk); #1;
    if (bdy) begin
      bus.bdy_in_tvalid = 1'b0; bus.bdy_out_tready = 4'h0; bus.bdy_in_tlast = 1'b0;
    end else begin
      bus.hdr_in_tvalid = 1'b0; bus.hdr_out_tready = 4'h0; bus.hdr_in_tlast = 1'b0;
    end
  endtask

  localparam logic [63:0] K_FULL = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    aresetn = 1'b0;
    lb_ctrl = 2'd0;
    idle_inputs();
    bus.hdr_out_tready = 4'hF;
    bus.bdy_out_tready = 4'hF;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;

    // Reset state
    @(negedge aclk);
    check_val("rst_meta_rdy", bus.meta_in_tready, 1'b1);
    check_val("rst_meta_vld", bus.meta_out_tvalid, 4'h0);
    check_val("rst_hdr_vld", bus.hdr_out_tvalid, 4'h0);
    check_val("rst_bdy_vld", bus.bdy_out_tvalid, 4'h0);
    check_val("rst_hdr_rdy", bus.hdr_in_tready, 1'b0);
    check_val("rst_bdy_rdy", bus.bdy_in_tready, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_meta_dat", bus.meta_out_tdata, 98'h0);
    check_cnt("rst_cnt", 128'h0);
    @(posedge aclk); #1;
    idle_inputs();

    // Full request to region 2: 3 header beats, 2 body beats
    send_meta(2, {48'hA1B2_C3D4_E5F6, 32'h4745_5420, 1'b1, 1'b1, 16'h0102}, 0);
    send_beat(1'b0, 2, {16{32'hA0A0_0001}}, K_FULL, 1'b0);
    send_beat(1'b0, 2, {16{32'hA0A0_0002}}, K_FULL, 1'b0);
    send_beat(1'b0, 2, {16{32'hA0A0_0003}}, 64'h0000_0000_0000_00FF, 1'b1);
    send_beat(1'b1, 2, {16{32'hB0B0_0001}}, K_FULL, 1'b0);
    send_beat(1'b1, 2, {16{32'hB0B0_0002}}, 64'h0000_0000_FFFF_FFFF, 1'b1);
    @(negedge aclk);
    check_val("t1_busy_drop", busy, 1'b0);
    check_val("t1_meta_rdy", bus.meta_in_tready, 1'b1);
    @(posedge aclk); #1;

    // Meta-only request to region 1 with ready withheld 4 cycles
    send_meta(1, {48'h0000_0000_0001, 32'h504F_5354, 1'b0, 1'b0, 16'h0007}, 4);
    @(negedge aclk);
    check_val("t2_busy", busy, 1'b0);
    check_val("t2_meta_rdy", bus.meta_in_tready, 1'b1);
    check_val("t2_meta_vld", bus.meta_out_tvalid, 4'h0);
    @(posedge aclk); #1;

    // Body-only request to region 0; lb_ctrl moves to 3 mid-body
    send_meta(0, {48'h0000_0000_0002, 32'h5055_5420, 1'b0, 1'b1, 16'h0033}, 0);
    send_beat(1'b1, 0, {16{32'hC0C0_0001}}, K_FULL, 1'b0);
    lb_ctrl = 2'd3;
    send_beat(1'b1, 0, {16{32'hC0C0_0002}}, K_FULL, 1'b0);
    send_beat(1'b1, 0, {16{32'hC0C0_0003}}, 64'h0000_0000_0000_000F, 1'b1);
    send_meta(3, {48'h0000_0000_0003, 32'h4445_4C20, 1'b0, 1'b0, 16'h0044}, 0);

    // Body beat waiting upstream before its meta arrives
    bus.bdy_in_tvalid  = 1'b1;
    bus.bdy_in_tdata   = {16{32'hE0E0_0001}};
    bus.bdy_in_tkeep   = K_FULL;
    bus.bdy_in_tlast   = 1'b0;
    bus.bdy_out_tready = 4'hF;
    @(negedge aclk);
    check_val("t4_early_rdy", bus.bdy_in_tready, 1'b0);
    check_val("t4_early_vld", bus.bdy_out_tvalid, 4'h0);
    @(posedge aclk); #1;
    send_meta(1, {48'h0000_0000_0004, 32'h5055_5420, 1'b0, 1'b1, 16'h0055}, 1);
    send_beat(1'b1, 1, {16{32'hE0E0_0001}}, K_FULL, 1'b0);
    send_beat(1'b1, 1, {16{32'hE0E0_0002}}, 64'h0000_0000_0000_0003, 1'b1);

    // Back-to-back requests to regions 0 and 3 from fresh counters
    aresetn = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    check_cnt("t5_cnt_clr", 128'h0);
    send_meta(0, {48'h0000_0000_0005, 32'h4745_5420, 1'b0, 1'b0, 16'h0066}, 0);
    check_cnt("t5_cnt_a", {32'd0, 32'd0, 32'd0, 32'd1});
    send_meta(3, {48'h0000_0000_0006, 32'h4745_5420, 1'b0, 1'b0, 16'h0077}, 0);
    check_cnt("t5_cnt_b", {32'd1, 32'd0, 32'd0, 32'd1});

    // Reset pulse while in the header phase
    send_meta(2, {48'h0000_0000_0007, 32'h4745_5420, 1'b1, 1'b1, 16'h0088}, 0);
    send_beat(1'b0, 2, {16{32'hF0F0_0001}}, K_FULL, 1'b0);
    bus.hdr_in_tvalid   = 1'b1;
    bus.hdr_in_tdata    = {16{32'hF0F0_0002}};
    bus.hdr_in_tkeep    = K_FULL;
    bus.hdr_out_tready  = 4'hF;
    bus.bdy_in_tvalid   = 1'b1;
    bus.bdy_out_tready  = 4'hF;
    bus.meta_out_tready = 4'hF;
    aresetn = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check_val("t6_meta_vld", bus.meta_out_tvalid, 4'h0);
    check_val("t6_hdr_vld", bus.hdr_out_tvalid, 4'h0);
    check_val("t6_bdy_vld", bus.bdy_out_tvalid, 4'h0);
    check_val("t6_hdr_rdy", bus.hdr_in_tready, 1'b0);
    check_val("t6_bdy_rdy", bus.bdy_in_tready, 1'b0);
    check_val("t6_meta_rdy", bus.meta_in_tready, 1'b1);
    check_val("t6_busy", busy, 1'b0);
    check_cnt("t6_cnt", 128'h0);
    @(posedge aclk); #1;
    idle_inputs();
    repeat (2) @(posedge aclk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/request_dispatcher.md
Name: request_dispatcher

Overview:
- Consumes the HTTP request triple (meta, header, body AXI4-Stream) and the per-request region decision `lb_ctrl` from the load balancer.
- Steers each complete request to exactly one of N_REGIONS region proxies, atomically: meta word, then header beats, then body beats, never interleaved.
- Sits between the HTTP module/load balancer and the region proxy inputs.

Parameters:
- HTTP_DATA_WIDTH, 512, header/body tdata width.
- HTTP_META_WIDTH, 98, meta word width: {meta_meta[47:0], method[31:0], has_hdr, has_bdy, oid[15:0]}.
- OPERATOR_ID_WIDTH, 16, oid width; has_bdy is bit OPERATOR_ID_WIDTH, has_hdr is bit OPERATOR_ID_WIDTH+1.
- N_REGIONS, 4, number of region outputs; power of two, ≥2.
- CNT_WIDTH, 32, width of per-region dispatch counters (optional feature).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- lb_ctrl  in  $clog2(N_REGIONS)  region decision from the load balancer.
- meta_in_tvalid/tready/tdata  in/out/in  1/1/HTTP_META_WIDTH  request meta stream.
- hdr_in_tvalid/tready/tdata/tkeep/tlast  in/out/in/in/in  1/1/HTTP_DATA_WIDTH/HTTP_DATA_WIDTH/8/1  header stream.
- bdy_in_*  same as hdr_in_*  body stream.
- meta_out_tvalid  out  N_REGIONS  per-region meta valid.
- meta_out_tready  in  N_REGIONS  per-region meta ready.
- meta_out_tdata  out  HTTP_META_WIDTH  shared meta data, broadcast to all regions.
- hdr_out_tvalid  out  N_REGIONS  per-region header valid.
- hdr_out_tready  in  N_REGIONS  per-region header ready.
- hdr_out_tdata/tkeep/tlast  out  shared header payload, broadcast to all regions.
- bdy_out_*  same as hdr_out_*  body stream.
- busy  out  1  high while a request is in flight (state ≠ IDLE).
- dispatch_cnt  out  N_REGIONS*CNT_WIDTH  per-region request counts; only with DISPATCH_CNT_EN.

Behaviour:
- Reset: state=IDLE; sel_q=0; meta register cleared.
  - All *_out_tvalid=0; all *_in_tready=0 except meta_in_tready=1; busy=0; counters=0.
- IDLE:
  - meta_in_tready=1.
  - On meta_in_tvalid: latch meta_in_tdata into meta_q and lb_ctrl into sel_q in the same cycle, then go to META.
- META:
  - meta_in_tready=0.
  - meta_out_tvalid[sel_q]=1, all other bits 0; meta_out_tdata=meta_q.
  - On meta_out_tready[sel_q]: go to HDR if has_hdr, else BDY if has_bdy, else IDLE.
  - Minimum meta latency is 1 cycle (registered).
- HDR:
  - Combinational pass-through: hdr_out_tvalid[sel_q]=hdr_in_tvalid; hdr_in_tready=hdr_out_tready[sel_q].
  - On an accepted beat with tlast: go to BDY if has_bdy, else IDLE.
- BDY:
  - Same pass-through on the body stream.
  - On an accepted tlast beat: go to IDLE.
- Streams not owned by the current state:
  - in-side tready=0; out-side tvalid=0.
  - Stray header/body beats wait upstream; they are never dropped.
- lb_ctrl is sampled only at meta acceptance. Changes mid-request are ignored.
- Back-to-back: IDLE→META takes one cycle, so there is at most 1 idle cycle between requests.
- Single-beat hdr/bdy (tlast on first beat) is legal.
- A request with both has_hdr=0 and has_bdy=0 completes in META.
- Non-selected out-ready bits have no effect.
- Reset mid-request: the request is abandoned, state returns to IDLE, and no tvalid is asserted in the cycle after reset.
- Undriven/out-of-range decisions are impossible because N_REGIONS is a power of two.

Optional Feature:
- DISPATCH_CNT_EN defined:
  - dispatch_cnt[r] increments by 1 on each META handshake to region r.
  - Wraps modulo 2^CNT_WIDTH.
  - Cleared by reset.
- DISPATCH_CNT_EN undefined:
  - The dispatch_cnt port and its logic are absent.

Decomposition:
- Package lb_pkg holds:
  - meta field offsets: OID_LSB, HAS_BDY_BIT, HAS_HDR_BIT, METHOD_LSB, META_META_LSB;
  - dispatch_state_t enum {IDLE, META, HDR, BDY};
  - the default widths.
- One sub-module, stream_demux: a generic 1-to-N valid/ready pass-through with a select input, instantiated for both hdr and bdy.

Test Plan:
- Full request, lb_ctrl=2, has_hdr=1, has_bdy=1, 3 hdr beats + 2 bdy beats:
  - only region 2 sees meta, then 3 hdr beats, then 2 bdy beats;
  - data/tkeep/tlast are bit-exact;
  - busy drops the cycle after the last bdy beat.
- Meta-only request (both flags 0) to region 1, with meta_out_tready[1] held low 4 cycles:
  - meta_out_tvalid[1] holds high with stable data for 4 cycles;
  - state returns to IDLE after the handshake.
- lb_ctrl toggled 0→3 mid-body of a request latched to region 0:
  - all remaining beats go to region 0;
  - the next request latches the then-current lb_ctrl.
- Body beats presented before meta (hdr absent, has_bdy=1):
  - bdy_in_tready stays 0 until META completes;
  - no beat is lost.
- Two back-to-back requests to regions 0 and 3:
  - at most 1 idle cycle between them;
  - with DISPATCH_CNT_EN, dispatch_cnt reads {0,0,0,1}→{1,0,0,1}.
- aresetn pulsed low during the HDR state:
  - all out tvalid=0 the next cycle;
  - meta_in_tready=1;
  - counters=0.
